mealy_overlap_1010: RTL and testbench
=====================================

Name: mealy_overlap_1010

Overview:
- Serial bit-stream pattern detector, Mealy style, with overlap.
- Flags every occurrence of the sequence 1-0-1-0 on a 1-bit input.
- Output is combinational from current state and current input, so the flag appears in the same cycle as the final 0.
- Used as a leaf block in serial-protocol front ends; one bit is consumed per clock.

Parameters:
- CNT_WIDTH, 8, width of the optional match counter. Unused unless MEALY_1010_CNT_EN is defined.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- x  input  1  serial data bit, sampled on each rising clock edge.
- y  output  1  detect flag; 1 while state is SEEN_101 and x=0.
- Positional instantiation order is fixed: (y, clock, reset, x).
- Optional port, present only with the macro: match_count, output, CNT_WIDTH bits.

Behaviour:
- Only rising clock edges update state; all state registers share the single clock domain.
- Reset: if reset==0 at a rising edge, state <= S0 regardless of x.
- y is forced 0 combinationally whenever reset==0, so y is 0 during reset, including before the first edge.
- States, 2-bit encoding:
  - S0=00: nothing matched.
  - S1=01: seen "1".
  - S2=10: seen "10".
  - S3=11: seen "101".
- Transitions (next state / y):
  - S0: x=1 -> S1/0; x=0 -> S0/0.
  - S1: x=1 -> S1/0; x=0 -> S2/0.
  - S2: x=1 -> S3/0; x=0 -> S0/0.
  - S3: x=0 -> S2/1 (overlap: the trailing "10" is reused); x=1 -> S1/0 (suffix "1" retained).
- y is purely combinational and has no registered stage.
  - Latency is zero: y rises as soon as x=0 is applied while in S3.
  - y is sampled by consumers at the next rising edge.
- Overlap consequence: the alternating stream 1,0,1,0,1,0,... detects on the 4th bit and every 2 bits after.
- Reset mid-sequence discards partial matches; detection restarts from S0.
- Illegal or unknown state (X after power-up, or any unreachable encoding) returns to S0 on the next edge and drives y=0.
- There is no enable input; every clock edge consumes one bit.

Optional Feature:
- Macro: MEALY_1010_CNT_EN.
- When defined:
  - Adds output match_count[CNT_WIDTH-1:0].
  - Counter increments by 1 at each rising edge where y==1, and wraps modulo 2^CNT_WIDTH.
  - Cleared to 0 by synchronous reset; reset takes priority over increment.
- When undefined: no match_count port and no counter logic. y behaviour is identical in both builds.

Test Plan:
- Hold reset=0 for 2 edges with x=1 -> y=0 throughout and state=S0. Release reset, drive x=0 for one edge -> y stays 0.
- After reset release, x per edge = 1,0,1,0,1,0 -> y=1 only during the 4th and 6th bits. Count builds: match_count=2.
- x = 1,1,0,1,0 -> y=1 only during the 5th bit. x = 1,0,0,1,0 -> y never asserts.
- x = 1,0,1,1,0,1,0 -> after "1011" the state returns to S1; y=1 only during the 7th bit.
- x = 1,0,1, then reset=0 for one edge, then reset=1 with x=0 -> y=0; state is S0 after reset.
- Clock period 10 ns, x toggling every 10 ns starting at 1, run 200 ns -> y pulses every 20 ns after the first full 1010. Count builds: match_count equals the number of pulses, and wraps correctly with CNT_WIDTH=2 after 4 matches.

Source files
------------

// File: rtl/mealy_overlap_1010.sv
// ---------------------------------------------------------------------------
// mealy_overlap_1010
//
// Purpose:
//   Serial pattern detector for the bit sequence 1-0-1-0, Mealy style, with
//   overlap. One bit is consumed on every rising clock edge. The detect flag
//   is combinational from the current state and the current input. It
//   therefore asserts in the same cycle that the final 0 is presented, and a
//   consumer samples it on the following rising edge.
//
// Ports:
//   y           output  1          detect flag (1 in SEEN_101 with x=0)
//   clock       input   1          rising-edge system clock
//   reset       input   1          synchronous, active-low reset (0 = reset)
//   x           input   1          serial data bit
//   match_count output  CNT_WIDTH  running match count; wraps modulo
//                                  2^CNT_WIDTH. Present only when
//                                  MEALY_1010_CNT_EN is defined.
//
// Parameters:
//   CNT_WIDTH   width of the optional match counter (default 8).
//
// Build option:
//   MEALY_1010_CNT_EN  when defined, adds the match_count output and its
//                      counter. The y behaviour is the same in both builds.
//
// Debug visibility:
//   The current FSM state is held in the internal signal 'state' (type
//   state_t), so checkers can bind to it by hierarchical reference.
//
// Handshake semantics:
//   There is no valid/ready pair. Every rising edge with reset=1 consumes x
//   unconditionally. y is valid whenever reset=1 and is forced to 0 while
//   reset=0.
// ---------------------------------------------------------------------------
module mealy_overlap_1010 #(
    parameter int CNT_WIDTH = 8
) (
    output logic                 y,
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 x
`ifdef MEALY_1010_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] match_count
`endif
);

    // Encoding is fixed: the state number equals the length of the prefix
    // matched so far.
    typedef enum logic [1:0] {
        S0 = 2'b00,   // nothing matched
        S1 = 2'b01,   // seen "1"
        S2 = 2'b10,   // seen "10"
        S3 = 2'b11    // seen "101"
    } state_t;

    state_t state;
    state_t state_next;

    // State register. Reset discards any partial match.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and detect logic.
    always_comb begin
        state_next = S0;
        y          = 1'b0;
        case (state)
            S0: state_next = x ? S1 : S0;
            S1: state_next = x ? S1 : S2;
            S2: state_next = x ? S3 : S0;
            S3: begin
                if (x) begin
                    // "1011": the trailing "1" can still start a new match.
                    state_next = S1;
                end else begin
                    // "1010" completes a match. The trailing "10" is reused
                    // as the prefix of the next match.
                    state_next = S2;
                    y          = reset;
                end
            end
            // An unknown state after power-up returns to S0 with y=0.
            default: begin
                state_next = S0;
                y          = 1'b0;
            end
        endcase
    end

`ifdef MEALY_1010_CNT_EN
    // Counts the edges at which a match is sampled. y is already gated by
    // reset, so reset has priority over the increment.
    always_ff @(posedge clock) begin
        if (!reset) begin
            match_count <= '0;
        end else if (y) begin
            match_count <= match_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mealy_overlap_1010.sv
// ---------------------------------------------------------------------------
// tb_mealy_overlap_1010
//
// Directed bench for mealy_overlap_1010. Inputs change on the falling edge.
// y is checked 1 ns after each input change, before the rising edge.
// The state (and the counter in count builds) is checked 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_mealy_overlap_1010;

    localparam int CW = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic x     = 1'b1;
    logic y;

    int total = 0;
    int bad   = 0;

`ifdef MEALY_1010_CNT_EN
    logic [CW-1:0] match_count;
    logic [CW-1:0] exp_cnt = '0;
`endif

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    mealy_overlap_1010 #(
        .CNT_WIDTH (CW)
    ) dut (
        .y           (y),
        .clock       (clock),
        .reset       (reset),
        .x           (x)
`ifdef MEALY_1010_CNT_EN
        ,
        .match_count (match_count)
`endif
    );

    // ---------------- checks ----------------
    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] exp);
        logic [1:0] obs;
        obs = dut.state;
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed state=%b expected state=%b", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Applies one bit, checks y before the edge, then clocks it in.
    task automatic step(input string tag, input logic xv, input logic rv,
                        input logic exp_y);
        x     = xv;
        reset = rv;
        #1;
        check_bit(tag, y, exp_y);
        @(posedge clock);
        #1;
`ifdef MEALY_1010_CNT_EN
        if (!rv) exp_cnt = '0;
        else if (exp_y) exp_cnt = exp_cnt + 1'b1;
        total++;
        assert (match_count === exp_cnt) else begin
            bad++;
            $error("FAIL %s_cnt: observed=%0d expected=%0d", tag, match_count, exp_cnt);
        end
`endif
        @(negedge clock);
    endtask

    // Runs n bits with reset released. Bit i of xs and ys is step i.
    task automatic run_seq(input string tag, input int n,
                           input logic [15:0] xs, input logic [15:0] ys);
        for (int i = 0; i < n; i++) begin
            step($sformatf("%s[%0d]", tag, i), xs[i], 1'b1, ys[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset held for 2 edges with x=1. y must already be 0 before the
        // first edge.
        step("rst0", 1'b1, 1'b0, 1'b0);
        check_state("rst0_state", 2'b00);
        step("rst1", 1'b1, 1'b0, 1'b0);
        check_state("rst1_state", 2'b00);
        // Release reset with x=0. The FSM stays in S0.
        step("rel_x0", 1'b0, 1'b1, 1'b0);
        check_state("rel_x0_state", 2'b00);

        // 1,0,1,0,1,0 -> y during the 4th and 6th bits.
        run_seq("alt6", 6, 16'b0000_0000_0001_0101, 16'b0000_0000_0010_1000);
        check_state("alt6_state", 2'b10);

        // 1,1,0,1,0 -> y during the 5th bit only.
        step("rst_a", 1'b0, 1'b0, 1'b0);
        run_seq("s11010", 5, 16'b0000_0000_0000_1011, 16'b0000_0000_0001_0000);

        // 1,0,0,1,0 -> y never asserts.
        step("rst_b", 1'b0, 1'b0, 1'b0);
        run_seq("s10010", 5, 16'b0000_0000_0000_1001, 16'b0000_0000_0000_0000);
        check_state("s10010_state", 2'b10);

        // 1,0,1,1 -> back to S1, then 0,1,0 -> y during the 7th bit.
        step("rst_c", 1'b0, 1'b0, 1'b0);
        run_seq("s1011", 4, 16'b0000_0000_0000_1101, 16'b0000_0000_0000_0000);
        check_state("s1011_state", 2'b01);
        run_seq("s010", 3, 16'b0000_0000_0000_0010, 16'b0000_0000_0000_0100);

        // 1,0,1, then reset with x=0. The FSM is in S3, but reset forces y=0.
        step("rst_d", 1'b0, 1'b0, 1'b0);
        run_seq("s101", 3, 16'b0000_0000_0000_0101, 16'b0000_0000_0000_0000);
        check_state("s101_state", 2'b11);
        step("rst_in_s3", 1'b0, 1'b0, 1'b0);
        check_state("rst_in_s3_state", 2'b00);
        step("post_rst_x0", 1'b0, 1'b1, 1'b0);
        check_state("post_rst_state", 2'b00);

        // Alternating stream of 20 bits, starting at 1. y pulses on every
        // second bit from the 4th bit (9 pulses; count wraps at CW=2).
        step("rst_e", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("stream[%0d]", i), (i % 2 == 0), 1'b1,
                 (i >= 3) && (i % 2 == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
